// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared types and opcode constants for the multicycle control FSM
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLL  = 4'b0101,
    ALU_SRL  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_SLT  = 4'b1000,
    ALU_SLTU = 4'b1001
  } alu_op_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // Only BEQ/BNE are implemented among the branches.
  function automatic logic is_legal(input logic [6:0] op, input logic [2:0] f3);
    return (op == OP_LOAD) || (op == OP_STORE) || (op == OP_IMM) || (op == OP_REG) ||
           ((op == OP_BRANCH) && (f3 == 3'b000 || f3 == 3'b001));
  endfunction

endpackage

// File: rtl/alu_dec.sv
// rtl/alu_dec.sv - maps opcode/funct3/funct7_5 to the ALU operation code
module alu_dec
  import ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output alu_op_t    alu_ctrl
);

  always_comb begin
    alu_ctrl = ALU_ADD;
    case (funct3)
      // I-type has no SUBI, so funct7_5 only matters for register ops here
      3'b000:  alu_ctrl = (opcode == OP_REG && funct7_5) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_ctrl = ALU_SLL;
      3'b010:  alu_ctrl = ALU_SLT;
      3'b011:  alu_ctrl = ALU_SLTU;
      3'b100:  alu_ctrl = ALU_XOR;
      3'b101:  alu_ctrl = funct7_5 ? ALU_SRA : ALU_SRL;
      3'b110:  alu_ctrl = ALU_OR;
      3'b111:  alu_ctrl = ALU_AND;
      default: alu_ctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - FETCH/DECODE/EXEC/MEM/WB sequencer with memory timeout and sticky traps
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       addr_sel,
  output logic       ir_we,
  output logic       pc_we,
  output logic       pc_src,
  output logic       alu_a_sel,
  output logic [1:0] alu_b_sel,
  output logic [3:0] alu_ctrl,
  output logic       reg_we,
  output logic       wb_sel,
  output logic       illegal,
  output logic       bus_err,
  output logic [2:0] state
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  state_t         st_q, st_d;
  logic [CW-1:0]  cnt_q;
  logic           illegal_q, bus_err_q;
  logic           set_ill, set_be;
  logic           waiting, timed_out;
  alu_op_t        dec_op;

  alu_dec u_alu_dec (
    .opcode   (opcode),
    .funct3   (funct3),
    .funct7_5 (funct7_5),
    .alu_ctrl (dec_op)
  );

  // The wait that would bring the count to the limit traps unless mem_ready arrives in it.
  assign waiting   = (st_q == S_FETCH || st_q == S_MEM) && !mem_ready;
  assign timed_out = waiting && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q      <= S_FETCH;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      st_q <= st_d;
      if (st_d != st_q)
        cnt_q <= '0;
      else if (waiting)
        cnt_q <= cnt_q + CW'(1);
      if (set_ill)
        illegal_q <= 1'b1;
      if (set_be)
        bus_err_q <= 1'b1;
    end
  end

  always_comb begin
    st_d      = st_q;
    set_ill   = 1'b0;
    set_be    = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    addr_sel  = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_src    = 1'b0;
    alu_a_sel = 1'b0;
    alu_b_sel = 2'b00;
    alu_ctrl  = ALU_ADD;
    reg_we    = 1'b0;
    wb_sel    = 1'b0;

    case (st_q)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we     = 1'b1;
          pc_we     = 1'b1;
          alu_a_sel = 1'b1;
          alu_b_sel = 2'b10;
          st_d      = S_DECODE;
        end else if (timed_out) begin
          st_d   = S_TRAP;
          set_be = 1'b1;
        end
      end
      S_DECODE: begin
        if (is_legal(opcode, funct3)) begin
          st_d = S_EXEC;
        end else begin
          st_d    = S_TRAP;
          set_ill = 1'b1;
        end
      end
      S_EXEC: begin
        st_d = S_FETCH;
        case (opcode)
          OP_LOAD, OP_STORE: begin
            alu_b_sel = 2'b01;
            st_d      = S_MEM;
          end
          OP_IMM: begin
            alu_b_sel = 2'b01;
            alu_ctrl  = dec_op;
            st_d      = S_WB;
          end
          OP_REG: begin
            alu_ctrl = dec_op;
            st_d     = S_WB;
          end
          OP_BRANCH: begin
            alu_ctrl = ALU_SUB;
            pc_src   = 1'b1;
            pc_we    = (funct3 == 3'b000) ? zero : !zero;
          end
          default: st_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = (opcode == OP_STORE);
        if (mem_ready) begin
          st_d = (opcode == OP_STORE) ? S_FETCH : S_WB;
        end else if (timed_out) begin
          st_d   = S_TRAP;
          set_be = 1'b1;
        end
      end
      S_WB: begin
        reg_we = 1'b1;
        wb_sel = (opcode == OP_LOAD);
        st_d   = S_FETCH;
      end
      S_TRAP:  st_d = S_TRAP;
      default: st_d = S_TRAP;
    endcase

    // State already reads FETCH during reset; keep every control quiet until release.
    if (!rst_n) begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      addr_sel  = 1'b0;
      ir_we     = 1'b0;
      pc_we     = 1'b0;
      pc_src    = 1'b0;
      alu_a_sel = 1'b0;
      alu_b_sel = 2'b00;
      alu_ctrl  = ALU_ADD;
      reg_we    = 1'b0;
      wb_sel    = 1'b0;
    end
  end

  assign illegal = illegal_q;
  assign bus_err = bus_err_q;
  assign state   = st_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - randomized bench for multicycle_ctrl against a per-instruction cycle-trace model
module tb_multicycle_ctrl;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] opcode = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       funct7_5 = 1'b0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_we, addr_sel, ir_we, pc_we, pc_src, alu_a_sel;
  logic [1:0] alu_b_sel;
  logic [3:0] alu_ctrl;
  logic       reg_we, wb_sel, illegal, bus_err;
  logic [2:0] state;

  multicycle_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
    .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .addr_sel(addr_sel), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src),
    .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .alu_ctrl(alu_ctrl), .reg_we(reg_we),
    .wb_sel(wb_sel), .illegal(illegal), .bus_err(bus_err), .state(state)
  );

  always #5 clk = ~clk;

  // {mem_req,mem_we,addr_sel,ir_we,pc_we,pc_src,alu_a_sel,alu_b_sel,alu_ctrl,reg_we,wb_sel,illegal,bus_err,state}
  logic [19:0] dut_vec, exp_vec;
  logic        exp_on = 1'b0;
  assign dut_vec = {mem_req, mem_we, addr_sel, ir_we, pc_we, pc_src, alu_a_sel,
                    alu_b_sel, alu_ctrl, reg_we, wb_sel, illegal, bus_err, state};

  typedef struct packed {
    logic        rdy;
    logic        z;
    logic [19:0] v;
  } ent_t;

  ent_t       q[$];
  logic       m_ill = 1'b0, m_be = 1'b0;
  logic [6:0] cur_op;
  logic [2:0] cur_f3;
  logic       cur_f7;
  int         total = 0, bad = 0;

  always @(negedge clk) begin
    if (exp_on) begin
      total++;
      if (dut_vec !== exp_vec) begin
        bad++;
        $display("FAIL cycle_outputs t=%0t got %h expected %h", $time, dut_vec, exp_vec);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // en = {mem_req,mem_we,addr_sel,ir_we,pc_we,pc_src,alu_a_sel}, wb = {reg_we,wb_sel}
  function automatic logic [19:0] f(input logic [2:0] st, input logic [6:0] en,
                                    input logic [1:0] bsel, input logic [3:0] ctl,
                                    input logic [1:0] wb);
    return {en, bsel, ctl, wb, m_ill, m_be, st};
  endfunction

  function automatic logic legal(input logic [6:0] op, input logic [2:0] f3);
    return op == 7'h03 || op == 7'h23 || op == 7'h13 || op == 7'h33 ||
           (op == 7'h63 && f3 < 3'd2);
  endfunction

  // Nibble k of the table is the operation for funct3 == k with funct7_5 clear.
  function automatic logic [3:0] exp_alu(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    logic [31:0] tbl;
    tbl = 32'h2364_9850;
    if (f3 == 3'd0 && op == 7'h33 && f7) return 4'd1;
    if (f3 == 3'd5 && f7) return 4'd7;
    return tbl[f3*4 +: 4];
  endfunction

  task automatic add_trap();
    for (int i = 0; i < 20; i++)
      q.push_back('{rb(), rb(), f(3'd5, 7'd0, 2'b00, 4'd0, 2'b00)});
  endtask

  task automatic build(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                       input int wf, input int wm, input logic z);
    logic ld, st_, br, taken;
    q.delete();
    cur_op = op; cur_f3 = f3; cur_f7 = f7;
    ld = (op == 7'h03); st_ = (op == 7'h23); br = (op == 7'h63);
    for (int i = 0; i < wf && i < TO; i++)
      q.push_back('{1'b0, rb(), f(3'd0, 7'b1000000, 2'b00, 4'd0, 2'b00)});
    if (wf >= TO) begin m_be = 1'b1; add_trap(); return; end
    q.push_back('{1'b1, rb(), f(3'd0, 7'b1001101, 2'b10, 4'd0, 2'b00)});
    q.push_back('{rb(), rb(), f(3'd1, 7'd0, 2'b00, 4'd0, 2'b00)});
    if (!legal(op, f3)) begin m_ill = 1'b1; add_trap(); return; end
    if (br) begin
      taken = (f3 == 3'd0) ? z : !z;
      q.push_back('{rb(), z, f(3'd2, {4'b0000, taken, 1'b1, 1'b0}, 2'b00, 4'd1, 2'b00)});
      return;
    end
    if (ld || st_) begin
      q.push_back('{rb(), rb(), f(3'd2, 7'd0, 2'b01, 4'd0, 2'b00)});
      for (int i = 0; i < wm && i < TO; i++)
        q.push_back('{1'b0, rb(), f(3'd3, {1'b1, st_, 1'b1, 4'b0000}, 2'b00, 4'd0, 2'b00)});
      if (wm >= TO) begin m_be = 1'b1; add_trap(); return; end
      q.push_back('{1'b1, rb(), f(3'd3, {1'b1, st_, 1'b1, 4'b0000}, 2'b00, 4'd0, 2'b00)});
      if (ld) q.push_back('{rb(), rb(), f(3'd4, 7'd0, 2'b00, 4'd0, 2'b11)});
      return;
    end
    q.push_back('{rb(), rb(), f(3'd2, 7'd0, (op == 7'h13) ? 2'b01 : 2'b00, exp_alu(op, f3, f7), 2'b00)});
    q.push_back('{rb(), rb(), f(3'd4, 7'd0, 2'b00, 4'd0, 2'b10)});
  endtask

  task automatic play(input int n);
    for (int i = 0; i < n && i < q.size(); i++) begin
      @(posedge clk); #1;
      rst_n = 1'b1;
      if (i == 0) begin opcode = cur_op; funct3 = cur_f3; funct7_5 = cur_f7; end
      mem_ready = q[i].rdy;
      zero      = q[i].z;
      exp_vec   = q[i].v;
      exp_on    = 1'b1;
    end
  endtask

  task automatic reset_dut();
    @(posedge clk); #1;
    rst_n = 1'b0;
    mem_ready = rb();
    m_ill = 1'b0; m_be = 1'b0;
    exp_vec = 20'd0;
    exp_on = 1'b1;
    #1;
    chk("reset_quiet", {25'd0, mem_req, mem_we, ir_we, pc_we, reg_we, illegal, bus_err}, 32'd0);
    chk("reset_state", {29'd0, state}, 32'd0);
    repeat (2) begin @(posedge clk); #1; mem_ready = rb(); end
  endtask

  initial begin
    logic [6:0] op;
    logic [2:0] f3;
    int cls, wf, wm;

    reset_dut();

    build(7'h33, 3'b000, 1'b1, 0, 0, 1'b0);
    chk("rsub_len", q.size(), 4);
    chk("rsub_exec_alu", q[2].v[10:7], 4'b0001);
    chk("rsub_wb_regwe", q[3].v[6], 1'b1);
    play(q.size());

    build(7'h03, 3'b010, 1'b0, 0, 3, 1'b0);
    chk("load_len", q.size(), 8);
    chk("load_wb_sel", q[7].v[6:5], 2'b11);
    play(q.size());

    build(7'h63, 3'b000, 1'b0, 0, 0, 1'b1);
    chk("beq_len", q.size(), 3);
    chk("beq_pcwe", q[2].v[15:14], 2'b11);
    play(q.size());
    build(7'h63, 3'b001, 1'b0, 0, 0, 1'b1);
    chk("bne_pcwe", q[2].v[15:14], 2'b01);
    play(q.size());

    build(7'h7f, 3'b000, 1'b0, 0, 0, 1'b0);
    chk("illegal_len", q.size(), 22);
    play(q.size());
    chk("illegal_flag", {30'd0, illegal, bus_err}, 32'd2);
    reset_dut();
    build(7'h63, 3'b100, 1'b0, 0, 0, 1'b0);
    play(q.size());
    chk("blt_illegal", {29'd0, state}, 32'd5);
    reset_dut();

    build(7'h33, 3'b111, 1'b0, TO, 0, 1'b0);
    chk("timeout_len", q.size(), TO + 20);
    chk("timeout_be_model", q[TO].v[3], 1'b1);
    play(q.size());
    chk("timeout_flag", {30'd0, illegal, bus_err}, 32'd1);
    reset_dut();
    build(7'h33, 3'b111, 1'b0, TO - 1, 0, 1'b0);
    chk("edge_len", q.size(), TO + 3);
    play(q.size());
    chk("edge_no_trap", {30'd0, illegal, bus_err}, 32'd0);

    build(7'h23, 3'b010, 1'b0, 0, 3, 1'b0);
    play(4);
    reset_dut();

    for (int n = 0; n < 150; n++) begin
      cls = $urandom_range(0, 5);
      case (cls)
        0: op = 7'h03;
        1: op = 7'h23;
        2: op = 7'h13;
        3: op = 7'h33;
        4: op = 7'h63;
        default: op = 7'($urandom);
      endcase
      f3 = 3'($urandom);
      wf = ($urandom_range(0, 29) == 0) ? TO : $urandom_range(0, 3);
      wm = ($urandom_range(0, 29) == 0) ? TO : $urandom_range(0, 3);
      build(op, f3, rb(), wf, wm, rb());
      play(q.size());
      if (m_ill || m_be) reset_dut();
    end

    @(posedge clk); #1;
    exp_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multicycle control FSM for the RV32I-subset core: sequences the shared ALU, memory port, instruction register, PC and register file through FETCH/DECODE/EXEC/MEM/WB for loads, stores, I-type ALU, R-type ALU and BEQ/BNE.
- Sits beside the immediate generator and ALU in the datapath.
- Consumes the IR opcode/funct fields and the ALU zero flag.
- Drives every write-enable and mux select.
- Adds a memory-handshake timeout and a sticky trap state.

## Interface
- TIMEOUT_CYCLES, 16: max cycles a memory request may wait for mem_ready before trapping (≥1).
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- opcode  in  7  IR[6:0].
- funct3  in  3  IR[14:12].
- funct7_5  in  1  IR[30].
- zero  in  1  ALU result == 0.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory request valid.
- mem_we  out  1  request is a write.
- addr_sel  out  1  memory address: 0 = PC, 1 = ALU result register.
- ir_we  out  1  load IR from memory read data.
- pc_we  out  1  update PC.
- pc_src  out  1  0 = ALU (PC+4), 1 = branch target (old PC + imm).
- alu_a_sel  out  1  0 = rs1, 1 = PC.
- alu_b_sel  out  2  00 = rs2, 01 = imm, 10 = constant 4.
- alu_ctrl  out  4  ALU operation code.
- reg_we  out  1  register-file write.
- wb_sel  out  1  0 = ALU result, 1 = memory read data.
- illegal  out  1  sticky: illegal opcode/funct3 trapped.
- bus_err  out  1  sticky: memory timeout trapped.
- state  out  3  current state, debug.

## Operation
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5. Unlisted outputs are 0 in every state.
- FETCH:
  - Asserts mem_req, addr_sel=0.
  - When mem_ready=1: also asserts ir_we and pc_we, with alu_a_sel=1, alu_b_sel=10, alu_ctrl=ADD, pc_src=0. Next state DECODE.
- DECODE: one cycle. Legal opcodes:
  - 0000011 (load), 0100011 (store), 0010011 (I-ALU), 0110011 (R-ALU).
  - 1100011 (branch), only with funct3 000 or 001.
  - Legal → EXEC. Anything else → TRAP and set illegal.
- EXEC by opcode:
  - Load/store: alu_b_sel=01, ADD → MEM.
  - I-ALU: alu_b_sel=01, alu_ctrl decoded → WB.
  - R-ALU: alu_b_sel=00, alu_ctrl decoded → WB.
  - Branch: alu_b_sel=00, SUB. taken = (funct3==000 ? zero : !zero). pc_we=taken, pc_src=1. → FETCH.
- ALU decode:
  - Codes: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLL 0101, SRL 0110, SRA 0111, SLT 1000, SLTU 1001.
  - By funct3: 000 → SUB for R-type with funct7_5=1, otherwise ADD (I-type ignores funct7_5).
  - 101 → funct7_5 selects SRA/SRL (both types). Remaining funct3 values map one-to-one.
- MEM:
  - Asserts mem_req, addr_sel=1, mem_we=1 for stores.
  - On mem_ready: store → FETCH; load → WB.
- WB: reg_we=1; wb_sel=1 for load, 0 otherwise. → FETCH.
- TRAP: all enables 0. Held until rst_n asserted.
- Timeout counter (width clog2(TIMEOUT_CYCLES+1)):
  - Cleared on every state change.
  - Increments each cycle in FETCH/MEM with mem_ready=0.
  - Reaching TIMEOUT_CYCLES with mem_ready still 0 → TRAP, set bus_err.
  - mem_ready=1 in the same cycle the count reaches the limit wins: the access completes and there is no trap.

## Timing
- Reset (async assert, synchronous-to-clk deassert by the system):
  - state=FETCH, counter=0, illegal=0, bus_err=0.
  - While rst_n=0, all enables and mem_req are forced 0.
- Outputs are combinational from state, IR fields, zero and mem_ready. Registers update on the rising edge.
- Zero-wait memory cycle counts: load 5, store 4, ALU 4, branch 3. Each memory wait cycle adds 1.
- mem_req holds stable until mem_ready. mem_ready while mem_req=0 is ignored.
- Reset asserted mid-instruction aborts it immediately; no partial write-enable is emitted after reset.

## Structure
- Package ctrl_pkg:
  - state_t enum (3-bit).
  - alu_op_t enum (4-bit, codes above).
  - Opcode localparams OP_LOAD, OP_STORE, OP_IMM, OP_REG, OP_BRANCH.
- Sub-module alu_dec: combinational (opcode, funct3, funct7_5) → alu_ctrl. Instantiated once in EXEC decode.

## Test plan
- R-type SUB (opcode 0110011, funct3 000, funct7_5=1), mem_ready tied 1 → states 0,1,2,4,0. alu_ctrl=0001 in EXEC, reg_we=1 in WB only, 4 cycles.
- Load with mem_ready delayed 3 cycles in MEM → mem_req/addr_sel=1 held 4 cycles, then WB with wb_sel=1. Total 8 cycles.
- BEQ with zero=1 then BNE with zero=1 → BEQ: pc_we=1, pc_src=1 in EXEC. BNE: pc_we=0. Both return to FETCH after 3 cycles.
- Opcode 1111111, then BLT (1100011, funct3 100) after reset → TRAP, illegal=1, all enables 0 for 20 cycles.
- mem_ready held 0 in FETCH, TIMEOUT_CYCLES=16 → TRAP with bus_err=1 after 16 wait cycles. Repeat with mem_ready=1 on cycle 16 → no trap, DECODE.
- rst_n pulsed low during MEM of a store → mem_req/mem_we drop the same cycle. After release: state=FETCH, illegal=bus_err=0.
